// File: rtl/lsu_pkg.sv
// Shared op encodings, FSM state type and op-decode helpers for the load/store unit.
package lsu_pkg;

  localparam logic [3:0] LB  = 4'h0;
  localparam logic [3:0] LH  = 4'h1;
  localparam logic [3:0] LW  = 4'h2;
  localparam logic [3:0] LD  = 4'h3;
  localparam logic [3:0] LBU = 4'h4;
  localparam logic [3:0] LHU = 4'h5;
  localparam logic [3:0] LWU = 4'h6;
  localparam logic [3:0] SB  = 4'h8;
  localparam logic [3:0] SH  = 4'h9;
  localparam logic [3:0] SW  = 4'hA;
  localparam logic [3:0] SD  = 4'hB;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [3:0] op);
    return 4'd1 << op[1:0];
  endfunction

  function automatic logic is_legal(input logic [3:0] op, input int xlen);
    logic [2:0] f3;
    f3 = op[2:0];
    if (op[3]) return !f3[2] && (f3[1:0] != 2'd3 || xlen == 64);
    return (f3 != 3'b111) && (xlen == 64 || (f3[1:0] != 2'd3 && f3 != 3'b110));
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [2:0] a);
    return (a & 3'(size_bytes(op) - 4'd1)) != 3'd0;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/mask placement and load extract with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int XLEN      = 32,
  localparam int NUM_LANES = XLEN / 8,
  localparam int OFF_W     = $clog2(NUM_LANES)
) (
  input  logic [2:0]           f3,
  input  logic [OFF_W-1:0]     off,
  input  logic [XLEN-1:0]      st_data,
  input  logic [XLEN-1:0]      ld_word,
  output logic [XLEN-1:0]      st_lane,
  output logic [NUM_LANES-1:0] st_mask,
  output logic [XLEN-1:0]      ld_data
);

  logic [3:0]      sz;
  logic [XLEN-1:0] ld_sh;

  assign sz      = size_bytes({1'b0, f3});
  assign st_lane = st_data << {off, 3'b000};
  assign ld_sh   = ld_word >> {off, 3'b000};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign st_mask[i] = (int'(off) <= i) && (i < int'(off) + int'(sz));
  end

  // f3[2] selects zero extension; size 3 only reaches here when XLEN=64.
  always_comb begin
    ld_data = ld_sh;
    case (f3[1:0])
      2'd0:    ld_data = f3[2] ? XLEN'(ld_sh[7:0])  : XLEN'($signed(ld_sh[7:0]));
      2'd1:    ld_data = f3[2] ? XLEN'(ld_sh[15:0]) : XLEN'($signed(ld_sh[15:0]));
      2'd2:    ld_data = f3[2] ? XLEN'(ld_sh[31:0]) : XLEN'($signed(ld_sh[31:0]));
      default: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Sequential LSU: valid/ready toward the core, single-outstanding registered handshake toward memory.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NUM_LANES = XLEN / 8;
  localparam int OFF_W     = $clog2(NUM_LANES);
  localparam int CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e state_q, state_d;

  logic [3:0]           op_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [XLEN-1:0]      wdata_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 hshake, tmo, bad_req;
  logic [XLEN-1:0]      al_wdata, al_rdata;
  logic [NUM_LANES-1:0] al_wmask;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .f3      (op_q[2:0]),
    .off     (addr_q[OFF_W-1:0]),
    .st_data (wdata_q),
    .ld_word (mem_rdata),
    .st_lane (al_wdata),
    .st_mask (al_wmask),
    .ld_data (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A completing handshake or read beat wins over a coincident timeout.
  always_comb begin
    state_d    = state_q;
    req_ready  = rst_n && (state_q == IDLE);
    resp_valid = (state_q == RESP);
    hshake     = mem_req_valid && mem_req_ready;
    tmo        = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST) && (state_q inside {ISSUE, WAIT});
    bad_req    = !is_legal(req_op, XLEN) || misaligned(req_op, req_addr[2:0]);
    case (state_q)
      IDLE:  if (req_valid) state_d = bad_req ? RESP : ISSUE;
      ISSUE: if (hshake) state_d = op_q[3] ? RESP : WAIT;
             else if (tmo) state_d = RESP;
      WAIT:  if (mem_rvalid || tmo) state_d = RESP;
      RESP:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          op_q       <= req_op;
          addr_q     <= req_addr;
          wdata_q    <= req_wdata;
          cnt_q      <= '0;
          resp_rdata <= '0;
          resp_err   <= bad_req;
        end
        // First ISSUE cycle registers the lane-steered request; it then holds until accepted.
        ISSUE: begin
          cnt_q <= cnt_q + 1'b1;
          if (hshake) begin
            mem_req_valid <= 1'b0;
          end else if (tmo) begin
            mem_req_valid <= 1'b0;
            resp_err      <= 1'b1;
          end else if (!mem_req_valid) begin
            mem_req_valid <= 1'b1;
            mem_we        <= op_q[3];
            mem_addr      <= {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
            mem_wdata     <= al_wdata;
            mem_wmask     <= op_q[3] ? al_wmask : '0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_rvalid) resp_rdata <= al_rdata;
          else if (tmo)   resp_err   <= 1'b1;
        end
        RESP: if (resp_ready) begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Sequential load/store unit for the NPC core. It sits between EXU/WBU and the data-memory port.
- Replaces the combinational DPI-style LSU with a valid/ready request/response interface toward the core and a registered single-outstanding handshake toward memory.
- Handles all RV32/RV64 load and store widths, including sign and zero extension.
- Detects misaligned or illegal ops and memory timeouts, and reports them as errors instead of silently dropping them.

Parameters:
XLEN, 32, data/register width; legal values 32 or 64.
ADDR_W, 32, address width.
TIMEOUT_CYC, 255, cycles spent in ISSUE or WAIT before a timeout error is raised; 0 disables the timeout.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  core request valid
req_ready  out  1  unit can accept a request
req_op  in  4  bit 3 is store; bits [2:0] are RISC-V funct3
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-aligned
resp_valid  out  1  result available
resp_ready  in  1  core accepts the result
resp_rdata  out  XLEN  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal or timeout
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts the request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  address aligned down to XLEN/8 bytes
mem_wdata  out  XLEN  store data shifted to its byte lane
mem_wmask  out  XLEN/8  byte-enable mask; all zero for reads
mem_rvalid  in  1  read data valid (pulse)
mem_rdata  in  XLEN  full aligned word

Behaviour:
- Reset is synchronous and active-low: while rst_n=0 on a clk edge, state goes to IDLE and all outputs are 0, except req_ready, which is 1 once rst_n=1. Reset mid-transaction abandons the transaction; no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/addr/wdata.
  - Legal and aligned op: go to ISSUE.
  - Otherwise: go to RESP with err=1, rdata=0, and no memory access.
- ISSUE:
  - mem_req_valid=1; mem_we, mem_addr, mem_wdata and mem_wmask are registered and stable until mem_req_ready.
  - Store: the handshake completes the store; go to RESP, err=0.
  - Load: go to WAIT.
- WAIT: on mem_rvalid, extract and extend the data, register it into resp_rdata, go to RESP. If mem_rvalid and the address handshake would be the same cycle, that cannot occur because WAIT starts the cycle after the handshake.
- RESP: resp_valid=1 and is held with stable data until resp_ready, then go to IDLE. The next request is accepted no earlier than the following cycle.
- Latency:
  - Store with mem_req_ready already high: 3 cycles from accept to resp_valid.
  - Load with zero-wait memory: 4 cycles.
- Size = funct3[1:0], giving 1/2/4/8 bytes. Unsigned = funct3[2].
- Illegal ops:
  - size=3 when XLEN=32.
  - Store with funct3[2]=1.
  - Load funct3=3'b111.
  - Load funct3=3'b110 (LWU) when XLEN=32.
- Misaligned: addr mod size != 0. It is always an error; accesses are never split.
- Lane offset = addr[log2(XLEN/8)-1:0].
- Store: wdata is shifted left by 8*offset; wmask = ((1<<size_bytes)-1) << offset.
- Load: rdata is shifted right by 8*offset, truncated to size, then sign- or zero-extended to XLEN.
- Timeout counter:
  - Cleared on entry to ISSUE.
  - Counts in ISSUE and WAIT.
  - When it reaches TIMEOUT_CYC: go to RESP with err=1 and rdata=0, and drop mem_req_valid.
- mem_rvalid is ignored in every state except WAIT; late data after a timeout is discarded.
- Only one transaction is outstanding at a time; there is no buffering beyond the latched request.

Decomposition:
- Package lsu_pkg holds:
  - Op encodings: LB=4'h0, LH=4'h1, LW=4'h2, LD=4'h3, LBU=4'h4, LHU=4'h5, LWU=4'h6, SB=4'h8, SH=4'h9, SW=4'hA, SD=4'hB.
  - The FSM state enum.
  - Functions size_bytes(op) and is_legal(op, XLEN).
- One combinational sub-module, lsu_lane_align, contains the store shift/mask and the load extract/extend. The FSM stays in the top.

Test Plan:
- XLEN=32. SW addr 0x80000004, data 0xDEADBEEF, mem_req_ready=1 -> mem_addr=0x80000004, wmask=4'hF, wdata=0xDEADBEEF; resp_valid 3 cycles after accept, err=0.
- SB addr 0x80000003, data 0x000000AB -> wmask=4'h8, wdata=0xAB000000.
- SH addr 0x80000002, data 0x1234 -> wmask=4'hC, wdata=0x12340000.
- mem_rdata=0x80FF7F01 returned for each load:
  - LB at offset 3 -> 0xFFFFFF80.
  - LBU at offset 3 -> 0x00000080.
  - LH at offset 2 -> 0xFFFF80FF.
  - LHU at offset 0 -> 0x00007F01.
- LW at addr 0x80000002 -> no mem_req_valid; resp_err=1 and rdata=0 on the cycle after accept.
- TIMEOUT_CYC=8, LW with mem_rvalid never asserted -> resp_err=1 after 8 cycles in ISSUE/WAIT. A later stray mem_rvalid in IDLE is ignored, and the next request completes normally.
- rst_n low for one edge while in WAIT, and separately hold resp_ready=0 for 5 cycles:
  - Reset case: all outputs are 0, no response is produced, and req_ready=1 once rst_n=1.
  - Held-response case: resp_valid and resp_rdata stay stable for all 5 cycles.
